convert_floatingpoint_to_integer_seq: RTL

CONVERT_FLOATINGPOINT_TO_INTEGER_SEQ -- requirements
Module: convert_floatingpoint_to_integer_seq

---
 rtl/convert_floatingpoint_to_integer_seq_pkg.sv | 38 +++
 rtl/convert_floatingpoint_to_integer_seq_fp_classify.sv | 59 +++++
 rtl/convert_floatingpoint_to_integer_seq.sv | 118 +++++++++++
 3 files changed

// File: rtl/convert_floatingpoint_to_integer_seq_pkg.sv
// Shared types and constants for the serial float-to-unsigned-integer converter.
// Holds the FSM state encoding, operand classes and the preset-result bundle.
package convert_floatingpoint_to_integer_seq_pkg;

  localparam int BIAS        = 127;
  localparam int INT_W       = 9;
  localparam int MANT_W      = 24;
  localparam int EXP_MAX_INT = 135;
  localparam int CNT_W       = 5;

  // Right-shift distance that turns the 24-bit significand into an integer is ALIGN_BASE - e.
  localparam int ALIGN_BASE  = BIAS + MANT_W - 1;

  localparam logic [INT_W-1:0] INT_SAT = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ALIGN = 2'd1,
    DONE  = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    CLS_NORMAL   = 3'd0,
    CLS_ZERO     = 3'd1,
    CLS_SMALL    = 3'd2,
    CLS_OVERFLOW = 3'd3,
    CLS_NAN      = 3'd4,
    CLS_NEGATIVE = 3'd5
  } fp_class_t;

  typedef struct packed {
    logic [INT_W-1:0] int_val;
    logic             overflow;
    logic             invalid;
    logic             inexact;
  } result_t;

endpackage

// File: rtl/convert_floatingpoint_to_integer_seq_fp_classify.sv
// Combinational operand classifier: sorts an IEEE-754 single into the converter's
// cases and supplies either the alignment shift count or the final preset result.
module fp_classify
  import convert_floatingpoint_to_integer_seq_pkg::*;
(
  input  logic [31:0]      fp,
  output fp_class_t        cls,
  output logic [CNT_W-1:0] shift,
  output result_t          preset
);

  localparam logic [7:0] EXP_BIAS    = 8'(BIAS);
  localparam logic [7:0] EXP_INT_MAX = 8'(EXP_MAX_INT);
  localparam logic [7:0] EXP_BASE    = 8'(ALIGN_BASE);

  logic       sign;
  logic [7:0] exp_f;
  logic       frac_nz;
  logic [7:0] shift_full;

  assign sign       = fp[31];
  assign exp_f      = fp[30:23];
  assign frac_nz    = |fp[22:0];
  assign shift_full = EXP_BASE - exp_f;

  always_comb begin
    cls    = CLS_NORMAL;
    shift  = '0;
    preset = '0;
    // NaN wins over the sign test so a negative NaN still saturates.
    if (exp_f == 8'hFF && frac_nz) begin
      cls             = CLS_NAN;
      preset.int_val  = INT_SAT;
      preset.overflow = 1'b1;
      preset.invalid  = 1'b1;
    end else if (sign) begin
      if (exp_f != 8'd0 || frac_nz) begin
        cls            = CLS_NEGATIVE;
        preset.invalid = 1'b1;
      end else begin
        cls = CLS_ZERO;
      end
    end else if (exp_f == 8'd0) begin
      cls            = CLS_ZERO;
      preset.inexact = frac_nz;
    end else if (exp_f < EXP_BIAS) begin
      cls            = CLS_SMALL;
      preset.inexact = 1'b1;
    end else if (exp_f > EXP_INT_MAX) begin
      cls             = CLS_OVERFLOW;
      preset.int_val  = INT_SAT;
      preset.overflow = 1'b1;
    end else begin
      cls   = CLS_NORMAL;
      shift = shift_full[CNT_W-1:0];
    end
  end

endmodule

// File: rtl/convert_floatingpoint_to_integer_seq.sv
// Serial float-to-9-bit-unsigned converter: normal operands are aligned one bit per
// cycle in ALIGN; special operands take a single ALIGN cycle with a preset result.
module convert_floatingpoint_to_integer_seq
  import convert_floatingpoint_to_integer_seq_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      FP,
  input  logic             valid_in,
  output logic             ready_out,
  output logic [INT_W-1:0] Int,
  output logic             valid_out,
  output logic             overflow,
  output logic             invalid,
  output logic             inexact,
  output state_t           dbg_state
);

  // Handshake: an operand is taken on a rising edge where valid_in && ready_out;
  // ready_out is high only in IDLE, and valid_out pulses for the one DONE cycle.

  state_t            state_q, state_d;
  logic [MANT_W-1:0] m_q, m_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              sticky_q, sticky_d;
  logic              pend_ovf_q, pend_ovf_d;
  logic              pend_inv_q, pend_inv_d;
  result_t           res_q, res_d;

  fp_class_t         cls;
  logic [CNT_W-1:0]  shift;
  result_t           preset;

  fp_classify u_classify (
    .fp     (FP),
    .cls    (cls),
    .shift  (shift),
    .preset (preset)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      m_q        <= '0;
      cnt_q      <= '0;
      sticky_q   <= 1'b0;
      pend_ovf_q <= 1'b0;
      pend_inv_q <= 1'b0;
      res_q      <= '0;
    end else begin
      state_q    <= state_d;
      m_q        <= m_d;
      cnt_q      <= cnt_d;
      sticky_q   <= sticky_d;
      pend_ovf_q <= pend_ovf_d;
      pend_inv_q <= pend_inv_d;
      res_q      <= res_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    m_d        = m_q;
    cnt_d      = cnt_q;
    sticky_d   = sticky_q;
    pend_ovf_d = pend_ovf_q;
    pend_inv_d = pend_inv_q;
    res_d      = res_q;
    case (state_q)
      IDLE: begin
        if (valid_in) begin
          state_d = ALIGN;
          if (cls == CLS_NORMAL) begin
            m_d        = {1'b1, FP[22:0]};
            cnt_d      = shift;
            sticky_d   = 1'b0;
            pend_ovf_d = 1'b0;
            pend_inv_d = 1'b0;
          end else begin
            // Preset rides the normal ALIGN path: one shift drops the guard zero.
            m_d        = MANT_W'({preset.int_val, 1'b0});
            cnt_d      = CNT_W'(1);
            sticky_d   = preset.inexact;
            pend_ovf_d = preset.overflow;
            pend_inv_d = preset.invalid;
          end
        end
      end
      ALIGN: begin
        m_d      = m_q >> 1;
        sticky_d = sticky_q | m_q[0];
        cnt_d    = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d        = DONE;
          res_d.int_val  = m_q[INT_W:1];
          res_d.overflow = pend_ovf_q;
          res_d.invalid  = pend_inv_q;
          res_d.inexact  = sticky_q | m_q[0];
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign ready_out = (state_q == IDLE);
  assign valid_out = (state_q == DONE);
  assign Int       = res_q.int_val;
  assign overflow  = res_q.overflow;
  assign invalid   = res_q.invalid;
  assign inexact   = res_q.inexact;
  assign dbg_state = state_q;

endmodule
